uart_tx_arbiter: RTL

//  Shares the single byte-wide UART transmitter between NREQ byte sources (ADC sample streamer,

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one byte-wide UART transmitter among NREQ sources, frame-locked by req_last; optional WAIT_START timeout via `define UART_ARB_TIMEOUT_EN.
// Latency: grant to tx_int low is 2 cycles (IDLE->LOAD->STROBE); at least 1+STROBE_CYC+1+1+max(1,GAP_CYC) cycles per byte plus transmitter frame time.
// Backpressure: one byte in flight; a requester holds req/data/last until its 1-cycle ack, and the transmitter paces via bps_start.
module uart_tx_arbiter #(
    parameter int NREQ       = 2,
    parameter int ID_W       = 1,
    parameter int STROBE_CYC = 4,
    parameter int GAP_CYC    = 0
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        tx_data,
    output logic              tx_int,
    input  logic              bps_start,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id,
    output logic              err_timeout
);

    localparam int CNT_W   = 16;
    localparam int GAP_LEN = (GAP_CYC == 0) ? 1 : GAP_CYC;

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_START, WAIT_DONE, GAP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic [7:0]       data_arr [NREQ];
`ifdef UART_ARB_TIMEOUT_EN
    logic             timeout_hit;
`endif

    // Requester index base+off, wrapped at NREQ so non-power-of-2 counts never go out of range.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        logic [ID_W:0] s;
        s = {1'b0, base} + (ID_W+1)'(off);
        if (s >= (ID_W+1)'(NREQ)) s = s - (ID_W+1)'(NREQ);
        return s[ID_W-1:0];
    endfunction

    // Unpack the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[8*i +: 8];
        end
    end

    // Winner selection: locked owner only, else first requester at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = grant_id;
        cand  = '0;
        if (lock) begin
            found = req[grant_id];
        end else begin
            // Scan from the far end so the smallest offset from rr_ptr is the last to win.
            for (int j = NREQ - 1; j >= 0; j--) begin
                cand = wrap_add(rr_ptr, j);
                if (req[cand]) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
        end
    end

    // Next-state logic for the per-byte handshake with the transmitter.
    always_comb begin
        state_nxt = state;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE:       if (found) state_nxt = LOAD;
            LOAD:       state_nxt = STROBE;
            STROBE:     if (cnt == CNT_W'(STROBE_CYC - 1)) state_nxt = WAIT_START;
            WAIT_START: begin
                if (bps_start) begin
                    state_nxt = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt   = GAP;
                    timeout_hit = 1'b1;
`endif
                end
            end
            WAIT_DONE:  if (!bps_start) state_nxt = GAP;
            GAP:        if (cnt == CNT_W'(GAP_LEN - 1)) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Decoded outputs: ack only during LOAD, strobe low only during STROBE so reset raises it at once.
    always_comb begin
        ack = '0;
        if (state == LOAD) ack[grant_id] = 1'b1;
    end

    assign tx_int = (state != STROBE);
    assign busy   = (state != IDLE);

    // State register; cnt restarts at zero on every state change and times STROBE, WAIT_START and GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
        end
    end

    // Grant, byte latch, frame lock and round-robin pointer; the pointer only moves at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id <= '0;
            tx_data  <= '0;
            lock     <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            if (state == IDLE && found) grant_id <= pick;
            if (state == LOAD) begin
                tx_data <= data_arr[grant_id];
                lock    <= ~req_last[grant_id];
                if (req_last[grant_id]) rr_ptr <= wrap_add(grant_id, 1);
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (timeout_hit) begin
                lock   <= 1'b0;
                rr_ptr <= wrap_add(grant_id, 1);
            end
`endif
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Sticky flag: the transmitter never acknowledged a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_timeout <= 1'b0;
        else if (timeout_hit) err_timeout <= 1'b1;
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule
